grant_responder: RTL and testbench

GRANT_RESPONDER -- requirements
Module: grant_responder

---
 rtl/grant_responder.sv | 136 +++++++++++++
 tb/tb_grant_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/grant_responder.sv
// grant_responder: round-robin single-owner grant FSM with registered outputs.
// Optional revoke/forced-withdraw path is built when GRANT_RESPONDER_REVOKE_EN is defined.
module grant_responder #(
    parameter int N_REQ        = 4,
    parameter int HOLD_CYCLES  = 16,
    parameter int FORCE_CYCLES = 8
) (
    input  logic                     i_ck,
    input  logic                     i_srst,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ-1:0]         i_release,
    output logic [N_REQ-1:0]         o_grant,
    output logic [N_REQ-1:0]         o_revoke,
    output logic [$clog2(N_REQ)-1:0] o_owner,
    output logic                     o_busy
);
    localparam int IW = $clog2(N_REQ);

`ifdef GRANT_RESPONDER_REVOKE_EN
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int FW = $clog2(FORCE_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, GRANT, REVOKE} state_t;
`else
    typedef enum logic [1:0] {IDLE, GRANT} state_t;
`endif

    state_t           state_q;
    logic [N_REQ-1:0] grant_q;
    logic [IW-1:0]    owner_q;
    logic             busy_q;
    logic [IW-1:0]    ptr_q;

    logic [IW-1:0]    winIdx;
    logic             winValid;
    logic [IW:0]      cand;
    logic [IW-1:0]    ptr_d;
    logic             ownerDone;

`ifdef GRANT_RESPONDER_REVOKE_EN
    logic [N_REQ-1:0] revoke_q;
    logic [HW-1:0]    holdCnt_q;
    logic [HW-1:0]    holdCnt_d;
    logic [FW-1:0]    forceCnt_q;
    logic             othersReq;

    assign holdCnt_d = holdCnt_q + HW'(1);
    assign othersReq = |(i_req & ~grant_q);
    assign o_revoke  = revoke_q;
`else
    assign o_revoke  = '0;
`endif

    // Scan from ptr_q upward with wrap; descending loop so the nearest candidate wins.
    always_comb begin
        winIdx   = '0;
        winValid = 1'b0;
        cand     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(N_REQ)) begin
                cand = cand - (IW+1)'(N_REQ);
            end
            if (i_req[cand[IW-1:0]]) begin
                winIdx   = cand[IW-1:0];
                winValid = 1'b1;
            end
        end
    end

    assign ptr_d     = (winIdx == IW'(N_REQ - 1)) ? '0 : winIdx + IW'(1);
    assign ownerDone = i_release[owner_q] | ~i_req[owner_q];

    always_ff @(posedge i_ck) begin
        if (i_srst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
`ifdef GRANT_RESPONDER_REVOKE_EN
            revoke_q   <= '0;
            holdCnt_q  <= '0;
            forceCnt_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (winValid) begin
                        state_q <= GRANT;
                        grant_q <= {{(N_REQ-1){1'b0}}, 1'b1} << winIdx;
                        owner_q <= winIdx;
                        busy_q  <= 1'b1;
                        ptr_q   <= ptr_d;
`ifdef GRANT_RESPONDER_REVOKE_EN
                        holdCnt_q <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (ownerDone) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end
`ifdef GRANT_RESPONDER_REVOKE_EN
                    else if (holdCnt_q == HW'(HOLD_CYCLES) && othersReq) begin
                        // The entry cycle counts as the first revoke cycle.
                        state_q    <= REVOKE;
                        revoke_q   <= grant_q;
                        forceCnt_q <= FW'(1);
                    end else if (holdCnt_q != HW'(HOLD_CYCLES)) begin
                        holdCnt_q <= holdCnt_d;
                    end
`endif
                end
`ifdef GRANT_RESPONDER_REVOKE_EN
                REVOKE: begin
                    if (ownerDone || forceCnt_q == FW'(FORCE_CYCLES)) begin
                        state_q  <= IDLE;
                        grant_q  <= '0;
                        revoke_q <= '0;
                        busy_q   <= 1'b0;
                    end else begin
                        forceCnt_q <= forceCnt_q + FW'(1);
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_grant = grant_q;
    assign o_owner = owner_q;
    assign o_busy  = busy_q;
endmodule

// File: tb/tb_grant_responder.sv
// Self-checking bench for grant_responder: directed scenarios plus randomized
// traffic, all compared against a behavioural owner/age model.
module tb_grant_responder;
    localparam int N     = 4;
    localparam int HOLD  = 16;
    localparam int FORCE = 8;
`ifdef GRANT_RESPONDER_REVOKE_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         srstIn = 1'b1;
    logic [N-1:0] reqIn = '0;
    logic [N-1:0] relIn = '0;
    logic [N-1:0] o_grant;
    logic [N-1:0] o_revoke;
    logic [1:0]   o_owner;
    logic         o_busy;

    int checkCount = 0;
    int errCount   = 0;

    // Reference model: owner index (-1 when free), last owner for rotation,
    // cycles spent owning, cycles spent under revoke.
    int mOwner    = -1;
    int mLast     = -1;
    int mShown    = 0;
    int mAge      = 0;
    int mRevAge   = 0;
    bit mRevoking = 1'b0;

    logic [N-1:0] prevGrant;

    grant_responder #(
        .N_REQ(N),
        .HOLD_CYCLES(HOLD),
        .FORCE_CYCLES(FORCE)
    ) dut (
        .i_ck(clk),
        .i_srst(srstIn),
        .i_req(reqIn),
        .i_release(relIn),
        .o_grant(o_grant),
        .o_revoke(o_revoke),
        .o_owner(o_owner),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
        end
    endtask

    // One clock edge of the reference behaviour, from the inputs seen at that edge.
    task modelStep(input logic [N-1:0] req, input logic [N-1:0] rel, input logic rst);
        int c;
        logic [N-1:0] ownerMask;
        if (rst) begin
            mOwner    = -1;
            mLast     = -1;
            mShown    = 0;
            mRevoking = 1'b0;
        end else if (mOwner < 0) begin
            for (int k = 0; k < N; k++) begin
                c = (mLast + 1 + k) % N;
                if (mOwner < 0 && req[c]) begin
                    mOwner = c;
                    mLast  = c;
                    mShown = c;
                    mAge   = 0;
                end
            end
        end else begin
            ownerMask = N'(1) << mOwner;
            if (rel[mOwner] || !req[mOwner]) begin
                mOwner    = -1;
                mRevoking = 1'b0;
            end else if (REV && mRevoking) begin
                if (mRevAge >= FORCE) begin
                    mOwner    = -1;
                    mRevoking = 1'b0;
                end else begin
                    mRevAge++;
                end
            end else if (REV && mAge >= HOLD && (req & ~ownerMask) != '0) begin
                mRevoking = 1'b1;
                mRevAge   = 1;
            end else begin
                mAge++;
            end
        end
    endtask

    task applyStimulus(input logic [N-1:0] req, input logic [N-1:0] rel, input logic rst);
        logic [N-1:0] expGrant;
        prevGrant = o_grant;
        reqIn  = req;
        relIn  = rel;
        srstIn = rst;
        @(posedge clk);
        modelStep(req, rel, rst);
        #1;
        expGrant = (mOwner >= 0) ? (N'(1) << mOwner) : '0;
        checkOutput("grant", o_grant, expGrant);
        checkOutput("revoke", o_revoke, mRevoking ? expGrant : '0);
        checkOutput("busy", o_busy, mOwner >= 0);
        checkOutput("owner", o_owner, mShown);
        checkOutput("gap", (prevGrant != '0 && o_grant != '0 && prevGrant != o_grant), 0);
    endtask

    initial begin
        logic [N-1:0] rReq;
        logic [N-1:0] rRel;
        logic         rRst;
        int           revokeCycles;

        // Reset state.
        applyStimulus('0, '0, 1'b1);
        applyStimulus('0, '0, 1'b1);
        checkOutput("rst_grant", o_grant, 0);
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_owner", o_owner, 0);

        // Single requester 2 wins from idle.
        applyStimulus(4'b0100, '0, 1'b0);
        checkOutput("first_grant", o_grant, 4'b0100);
        checkOutput("first_owner", o_owner, 2);
        checkOutput("first_busy", o_busy, 1);

        // Owner 2 releases: gap, then 3, then 0 after 3 releases.
        applyStimulus(4'b1111, 4'b0100, 1'b0);
        checkOutput("rr_gap", o_grant, 0);
        checkOutput("rr_owner_held", o_owner, 2);
        applyStimulus(4'b1011, '0, 1'b0);
        checkOutput("rr_next3", o_grant, 4'b1000);
        applyStimulus(4'b1011, '0, 1'b0);
        applyStimulus(4'b1011, 4'b1000, 1'b0);
        checkOutput("rr_gap2", o_grant, 0);
        applyStimulus(4'b0011, '0, 1'b0);
        checkOutput("rr_wrap0", o_grant, 4'b0001);

        // Owner 0 holds with requester 1 waiting: revoke once the hold expires.
        for (int i = 0; i < 16; i++) applyStimulus(4'b0011, '0, 1'b0);
        checkOutput("hold_no_revoke", o_revoke, 0);
        applyStimulus(4'b0011, '0, 1'b0);
        checkOutput("hold_revoke", o_revoke, REV ? 4'b0001 : 4'b0000);
        applyStimulus(4'b0011, 4'b0001, 1'b0);
        checkOutput("revoke_rel_gap", o_grant, 0);
        checkOutput("revoke_rel_clear", o_revoke, 0);
        applyStimulus(4'b0011, '0, 1'b0);
        checkOutput("revoke_next", o_grant, 4'b0010);

        // Owner 1 ignores the revoke: forced withdrawal, then requester 2.
        revokeCycles = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(4'b0111, '0, 1'b0);
            if (o_revoke != '0) revokeCycles++;
        end
        checkOutput("force_len", revokeCycles, REV ? FORCE : 0);
        checkOutput("force_next", o_grant, REV ? 4'b0100 : 4'b0010);

        // Release lands exactly on hold expiry: no revoke, straight to idle.
        applyStimulus('0, '0, 1'b0);
        applyStimulus(4'b0001, '0, 1'b0);
        checkOutput("coin_owner", o_grant, 4'b0001);
        for (int i = 0; i < 16; i++) applyStimulus(4'b0011, '0, 1'b0);
        applyStimulus(4'b0011, 4'b0001, 1'b0);
        checkOutput("coin_revoke", o_revoke, 0);
        checkOutput("coin_idle", o_busy, 0);
        applyStimulus(4'b0011, '0, 1'b0);
        checkOutput("coin_next", o_grant, 4'b0010);

        // Reset mid-grant drops the grant and restarts the rotation at 0.
        applyStimulus(4'b0011, '0, 1'b0);
        applyStimulus(4'b0011, '0, 1'b1);
        checkOutput("midrst_grant", o_grant, 0);
        checkOutput("midrst_busy", o_busy, 0);
        applyStimulus(4'b0011, '0, 1'b0);
        checkOutput("midrst_ptr0", o_grant, 4'b0001);

        // Randomized traffic with slowly changing requests.
        rReq = 4'b0000;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(23) == 0) rReq = N'($urandom);
            rRel = ($urandom_range(29) == 0) ? (N'(1) << $urandom_range(N - 1)) : '0;
            rRst = ($urandom_range(399) == 0);
            applyStimulus(rReq, rRel, rRst);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule
